// File: rtl/fetch_pkg.sv
// Shared types and instruction-field positions for the tinymips fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int TGT_MSB   = 25;
  localparam int TGT_LSB   = 0;

  // Word-scaled, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: sequential, taken branch, or jump (jump wins).
module pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic        unused_op;

  assign pc4       = pc + 32'd4;
  assign unused_op = ^instr[OP_MSB:OP_LSB];

  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[31:28], instr[TGT_MSB:TGT_LSB], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc4 + branch_offset(instr[IMM_MSB:IMM_LSB]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, holds the word until consumed.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  OP,
  output logic [5:0]  Funct,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        JUMP,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic [1:0]  state
);

  // Handshakes: imem_req is held with a stable imem_addr until imem_ack is seen on a
  // rising edge; instr_valid holds instr/pc stable until instr_ready is seen on an edge.
  fetch_state_t state_q, state_next;
  logic [31:0]  pc_q, instr_q, next_pc;
  logic         latch, consume;

  always_comb begin
    state_next  = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    latch       = 1'b0;
    consume     = 1'b0;
    unique case (state_q)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          latch      = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          consume    = 1'b1;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_next;
      if (latch)   instr_q <= imem_rdata;
      if (consume) pc_q    <= next_pc;
    end
  end

  // Control inputs only matter through next_pc, which is used solely on consume.
  pc_next u_pc_next (
    .pc      (pc_q),
    .instr   (instr_q),
    .branch  (Branch),
    .zero    (Zero),
    .jump    (JUMP),
    .next_pc (next_pc)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (consume) perf_fetched <= perf_fetched + 32'd1;
      if ((state_q == S_FETCH && !imem_ack) || (state_q == S_HOLD && !instr_ready))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign OP        = instr_q[OP_MSB:OP_LSB];
  assign Funct     = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign state     = state_q;

endmodule
